// File: rtl/lce_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lce_pkg
// Brief   : Shared types and frame geometry for the LCE tile scheduler.
// Revision: 1.0  initial release
// ============================================================================
package lce_pkg;

    localparam int c_img_w  = 240;
    localparam int c_img_h  = 240;
    localparam int c_tile_w = 60;
    localparam int c_tile_h = 60;
    localparam int c_ntx    = c_img_w / c_tile_w;
    localparam int c_nty    = c_img_h / c_tile_h;
    localparam int c_nt     = c_ntx * c_nty;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HIST_GO   = 3'd1,
        ST_HIST_WAIT = 3'd2,
        ST_MAP_ISSUE = 3'd3,
        ST_MAP_WAIT  = 3'd4,
        ST_NEXT_TILE = 3'd5,
        ST_FIN       = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_HIST = 2'd1,
        GNT_CDF  = 2'd2
    } grant_t;

    // Counter width that never collapses to zero bits for a range of 1.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lce_bram_mux.sv
`default_nettype none
// ============================================================================
// Module  : lce_bram_mux
// Brief   : Grant-selected BRAM port mux; the non-granted requester is dropped.
// Revision: 1.0  initial release
// ============================================================================
module lce_bram_mux
    import lce_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  grant_t            grant,
    input  logic              hist_ren,
    input  logic              hist_wen,
    input  logic [ADDR_W-1:0] hist_addr,
    input  logic [7:0]        hist_din,
    input  logic              cdf_ren,
    input  logic              cdf_wen,
    input  logic [ADDR_W-1:0] cdf_addr,
    input  logic [7:0]        cdf_din,
    output logic              bram_ren,
    output logic              bram_wen,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_din
);

    always_comb begin
        bram_ren  = 1'b0;
        bram_wen  = 1'b0;
        bram_addr = '0;
        bram_din  = '0;
        case (grant)
            GNT_HIST: begin
                bram_ren  = hist_ren;
                bram_wen  = hist_wen;
                bram_addr = hist_addr;
                bram_din  = hist_din;
            end
            GNT_CDF: begin
                bram_ren  = cdf_ren;
                bram_wen  = cdf_wen;
                bram_addr = cdf_addr;
                bram_din  = cdf_din;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lce_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : lce_tile_scheduler
// Brief   : Per-tile histogram / CDF / remap sequencer with BRAM arbitration.
// Revision: 1.0  initial release
// ============================================================================
module lce_tile_scheduler
    import lce_pkg::*;
#(
    parameter int IMG_W    = c_img_w,
    parameter int IMG_H    = c_img_h,
    parameter int TILE_W   = c_tile_w,
    parameter int TILE_H   = c_tile_h,
    parameter int ADDR_W   = 17,
    parameter int WDOG_CYC = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        tile_idx,
    output logic              hist_start,
    input  logic              hist_done,
    output logic              cdf_start,
    input  logic              cdf_done,
    output logic [ADDR_W-1:0] map_index,
    input  logic              hist_ren,
    input  logic              hist_wen,
    input  logic [ADDR_W-1:0] hist_addr,
    input  logic [7:0]        hist_din,
    input  logic              cdf_ren,
    input  logic              cdf_wen,
    input  logic [ADDR_W-1:0] cdf_addr,
    input  logic [7:0]        cdf_din,
    output logic              bram_ren,
    output logic              bram_wen,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_din
);

    localparam int c_tiles_x = IMG_W / TILE_W;
    localparam int c_tiles_y = IMG_H / TILE_H;
    localparam int c_tiles   = c_tiles_x * c_tiles_y;
    localparam int c_px_w    = clog2_min1(TILE_W);
    localparam int c_py_w    = clog2_min1(TILE_H);
    localparam int c_tx_w    = clog2_min1(c_tiles_x);
    localparam int c_ty_w    = clog2_min1(c_tiles_y);
    localparam int c_wd_w    = $clog2(WDOG_CYC + 1);

    state_t              r_state;
    state_t              w_next;
    grant_t              r_grant;
    grant_t              w_grant_next;
    logic [c_px_w-1:0]   r_px;
    logic [c_py_w-1:0]   r_py;
    logic [c_tx_w-1:0]   r_tx;
    logic [c_ty_w-1:0]   r_ty;
    logic [7:0]          r_tile;
    logic                r_err;
    logic                r_cdf_ack;
    logic [c_wd_w-1:0]   r_wdog;

    logic w_accept, w_waiting, w_wdog_hit, w_pix_done;
    logic w_px_last, w_py_last, w_tx_last, w_tile_last;

    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_waiting   = (r_state == ST_HIST_WAIT) || (r_state == ST_MAP_WAIT);
    assign w_wdog_hit  = w_waiting && (r_wdog == c_wd_w'(WDOG_CYC));
    // A pixel retires only once the engine has acknowledged and then released done.
    assign w_pix_done  = (r_state == ST_MAP_WAIT) && r_cdf_ack && !cdf_done && !w_wdog_hit;
    assign w_px_last   = (r_px == c_px_w'(TILE_W - 1));
    assign w_py_last   = (r_py == c_py_w'(TILE_H - 1));
    assign w_tx_last   = (r_tx == c_tx_w'(c_tiles_x - 1));
    assign w_tile_last = (r_tile == 8'(c_tiles - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= GNT_NONE;
        end else begin
            r_state <= w_next;
            r_grant <= w_grant_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (start) w_next = ST_HIST_GO;
            ST_HIST_GO:   w_next = ST_HIST_WAIT;
            ST_HIST_WAIT: begin
                if (w_wdog_hit)     w_next = ST_FIN;
                else if (hist_done) w_next = ST_MAP_ISSUE;
            end
            ST_MAP_ISSUE: w_next = ST_MAP_WAIT;
            ST_MAP_WAIT: begin
                if (w_wdog_hit)                    w_next = ST_FIN;
                else if (w_pix_done && w_px_last && w_py_last) w_next = ST_NEXT_TILE;
                else if (w_pix_done)               w_next = ST_MAP_ISSUE;
            end
            ST_NEXT_TILE: w_next = w_tile_last ? ST_FIN : ST_HIST_GO;
            ST_FIN:       w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase

        // Grant follows the state being entered, so it never switches mid-access.
        w_grant_next = GNT_NONE;
        case (w_next)
            ST_HIST_WAIT:             w_grant_next = GNT_HIST;
            ST_MAP_ISSUE, ST_MAP_WAIT: w_grant_next = GNT_CDF;
            default:                  w_grant_next = GNT_NONE;
        endcase
    end

    always_comb begin
        busy       = (r_state != ST_IDLE) && (r_state != ST_FIN);
        done       = (r_state == ST_FIN);
        hist_start = (r_state == ST_HIST_GO);
        cdf_start  = (r_state == ST_MAP_ISSUE) || ((r_state == ST_MAP_WAIT) && !r_cdf_ack);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_px      <= '0;
            r_py      <= '0;
            r_tx      <= '0;
            r_ty      <= '0;
            r_tile    <= 8'd0;
            r_err     <= 1'b0;
            r_cdf_ack <= 1'b0;
            r_wdog    <= '0;
        end else begin
            if (w_next != r_state)
                r_wdog <= '0;
            else if (w_waiting)
                r_wdog <= r_wdog + c_wd_w'(1);

            if (r_state == ST_MAP_ISSUE)
                r_cdf_ack <= 1'b0;
            else if ((r_state == ST_MAP_WAIT) && cdf_done)
                r_cdf_ack <= 1'b1;

            if (w_accept) begin
                r_px   <= '0;
                r_py   <= '0;
                r_tx   <= '0;
                r_ty   <= '0;
                r_tile <= 8'd0;
                r_err  <= 1'b0;
            end else if (w_wdog_hit) begin
                r_err <= 1'b1;
            end

            if (w_pix_done) begin
                if (w_px_last) begin
                    r_px <= '0;
                    r_py <= w_py_last ? '0 : r_py + c_py_w'(1);
                end else begin
                    r_px <= r_px + c_px_w'(1);
                end
            end

            if ((r_state == ST_NEXT_TILE) && !w_tile_last) begin
                r_tile <= r_tile + 8'd1;
                if (w_tx_last) begin
                    r_tx <= '0;
                    r_ty <= r_ty + c_ty_w'(1);
                end else begin
                    r_tx <= r_tx + c_tx_w'(1);
                end
            end
        end
    end

    assign err      = r_err;
    assign tile_idx = r_tile;
    assign map_index = (ADDR_W'(r_ty) * ADDR_W'(TILE_H) + ADDR_W'(r_py)) * ADDR_W'(IMG_W)
                     + ADDR_W'(r_tx) * ADDR_W'(TILE_W) + ADDR_W'(r_px);

    lce_bram_mux #(
        .ADDR_W (ADDR_W)
    ) u_bram_mux (
        .grant     (r_grant),
        .hist_ren  (hist_ren),
        .hist_wen  (hist_wen),
        .hist_addr (hist_addr),
        .hist_din  (hist_din),
        .cdf_ren   (cdf_ren),
        .cdf_wen   (cdf_wen),
        .cdf_addr  (cdf_addr),
        .cdf_din   (cdf_din),
        .bram_ren  (bram_ren),
        .bram_wen  (bram_wen),
        .bram_addr (bram_addr),
        .bram_din  (bram_din)
    );

endmodule
`default_nettype wire

// File: tb/tb_lce_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_lce_tile_scheduler
// Brief   : Self-checking bench for lce_tile_scheduler on a reduced frame size.
// Revision: 1.0  initial release
// ============================================================================
module tb_lce_tile_scheduler;

    localparam int W    = 16;
    localparam int H    = 12;
    localparam int TW   = 4;
    localparam int TH   = 3;
    localparam int AW   = 17;
    localparam int WD   = 40;
    localparam int NT   = (W / TW) * (H / TH);
    localparam int TPIX = TW * TH;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst, start;
    logic          busy, done, err, hist_start, cdf_start;
    logic [7:0]    tile_idx;
    logic          hd_model, hd_stray, hist_done, cdf_done;
    logic [AW-1:0] map_index;
    logic          hist_ren, hist_wen, cdf_ren, cdf_wen;
    logic [AW-1:0] hist_addr, cdf_addr;
    logic [7:0]    hist_din, cdf_din;
    logic          bram_ren, bram_wen;
    logic [AW-1:0] bram_addr;
    logic [7:0]    bram_din;

    assign hist_done = hd_model | hd_stray;

    lce_tile_scheduler #(
        .IMG_W(W), .IMG_H(H), .TILE_W(TW), .TILE_H(TH), .ADDR_W(AW), .WDOG_CYC(WD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .tile_idx(tile_idx), .hist_start(hist_start), .hist_done(hist_done),
        .cdf_start(cdf_start), .cdf_done(cdf_done), .map_index(map_index),
        .hist_ren(hist_ren), .hist_wen(hist_wen), .hist_addr(hist_addr), .hist_din(hist_din),
        .cdf_ren(cdf_ren), .cdf_wen(cdf_wen), .cdf_addr(cdf_addr), .cdf_din(cdf_din),
        .bram_ren(bram_ren), .bram_wen(bram_wen), .bram_addr(bram_addr), .bram_din(bram_din)
    );

    initial forever #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_hist = 0;
    int            n_done = 0;
    logic [AW-1:0] q_idx[$];
    int            exp_idx[$];
    bit            hist_en = 1'b1;
    int            cdf_hold_fix = -1;

    // Histogram engine: pulses done a random 1..5 cycles after each start.
    initial begin
        hd_model = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (hist_start && hist_en) begin
                repeat ($urandom_range(1, 5)) begin @(posedge clk); #1; end
                hd_model = 1'b1;
                @(posedge clk); #1;
                hd_model = 1'b0;
            end
        end
    end

    // CDF engine: raises done after random latency, drops it some cycles after start falls.
    initial begin
        cdf_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (cdf_start) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                cdf_done = 1'b1;
                while (cdf_start) begin @(posedge clk); #1; end
                repeat ((cdf_hold_fix >= 0) ? cdf_hold_fix : int'($urandom_range(0, 2))) begin
                    @(posedge clk); #1;
                end
                cdf_done = 1'b0;
            end
        end
    end

    // Observer: one index per cdf_start rising edge, plus pulse counts.
    initial begin
        logic prev_cs;
        prev_cs = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_cs = 1'b0;
            end else begin
                if (hist_start) n_hist++;
                if (done) n_done++;
                if (cdf_start && !prev_cs) q_idx.push_back(map_index);
                prev_cs = cdf_start;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // mode 0: cdf_done high; 1: hist_start in tile; 2: cdf_start in tile; 3: done
    task automatic wait_cond(input int mode, input int tile, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if ((mode == 0 && cdf_done) ||
                (mode == 1 && hist_start && tile_idx == 8'(tile)) ||
                (mode == 2 && cdf_start && tile_idx == 8'(tile)) ||
                (mode == 3 && done)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_frame(input string tag, input int base_q, input int base_h, input int base_d);
        int mism;
        mism = 0;
        check({tag, "_hist_pulses"}, 64'(n_hist - base_h), 64'(NT));
        check({tag, "_done_pulses"}, 64'(n_done - base_d), 64'd1);
        check({tag, "_pix_count"}, 64'(q_idx.size() - base_q), 64'(NPIX));
        for (int i = 0; i < NPIX; i++) begin
            if (base_q + i >= q_idx.size()) mism++;
            else if (q_idx[base_q + i] !== AW'(exp_idx[i])) mism++;
        end
        check({tag, "_pix_order"}, 64'(mism), 64'd0);
    endtask

    initial begin
        bit ok;
        int bq, bh, bd, k;
        logic last_cs;

        // Reference pixel order: tiles row-major, pixels row-major within a tile.
        for (int ty = 0; ty < H / TH; ty++)
            for (int tx = 0; tx < W / TW; tx++)
                for (int py = 0; py < TH; py++)
                    for (int px = 0; px < TW; px++)
                        exp_idx.push_back((ty * TH + py) * W + (tx * TW + px));

        rst = 1'b1; start = 1'b0; hd_stray = 1'b0;
        hist_ren = 1'b1; hist_wen = 1'b1; hist_addr = AW'(123); hist_din = 8'h5A;
        cdf_ren = 1'b1;  cdf_wen = 1'b1;  cdf_addr = AW'(77);   cdf_din = 8'hA5;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_tile", tile_idx, 0);
        check("rst_index", map_index, 0);
        check("rst_hist_start", hist_start, 0);
        check("rst_cdf_start", cdf_start, 0);
        check("rst_bram", {bram_ren, bram_wen, bram_addr, bram_din}, 0);
        hist_ren = 1'b0; hist_wen = 1'b0; cdf_ren = 1'b0; cdf_wen = 1'b0;
        rst = 1'b0;

        // ---- Frame A: full run, cdf_done hold, restart-while-busy, grant isolation
        bq = q_idx.size(); bh = n_hist; bd = n_done;
        cdf_hold_fix = 2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("a_hist_start", hist_start, 1);
        check("a_busy", busy, 1);
        check("a_tile0", tile_idx, 0);

        wait_cond(0, 0, 200, ok);
        check("a_cdf_done_seen", ok, 1);
        k = 0; last_cs = 1'b1;
        while (cdf_done && k < 20) begin
            check("hold_index", map_index, exp_idx[0]);
            last_cs = cdf_start;
            k++;
            @(negedge clk);
        end
        check("hold_len_ge3", k >= 3, 1);
        check("hold_cs_dropped", last_cs, 0);
        check("hold_index_after_fall", map_index, exp_idx[0]);
        @(negedge clk);
        check("next_pixel_index", map_index, exp_idx[1]);
        check("next_pixel_cs", cdf_start, 1);
        cdf_hold_fix = -1;

        wait_cond(1, 3, 8000, ok);
        check("a_tile3_seen", ok, 1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("restart_tile", tile_idx, 3);
        check("restart_index", map_index, exp_idx[3 * TPIX]);
        check("restart_busy", busy, 1);

        wait_cond(2, 5, 8000, ok);
        check("a_tile5_seen", ok, 1);
        cdf_wen = 1'b1; cdf_ren = 1'b0; cdf_addr = AW'($urandom_range(1, 100000)); cdf_din = 8'($urandom);
        hist_wen = 1'b1; hist_ren = 1'b1; hist_addr = ~cdf_addr; hist_din = ~cdf_din;
        hd_stray = 1'b1;
        @(negedge clk);
        check("map_bram_wen", bram_wen, 1);
        check("map_bram_ren", bram_ren, 0);
        check("map_bram_addr", bram_addr, cdf_addr);
        check("map_bram_din", bram_din, cdf_din);
        cdf_wen = 1'b0; hist_wen = 1'b0; hist_ren = 1'b0; hd_stray = 1'b0;

        wait_cond(3, 0, 8000, ok);
        check("a_done_seen", ok, 1);
        check("a_err", err, 0);
        check("a_busy_at_done", busy, 0);
        check("a_last_tile", tile_idx, NT - 1);
        repeat (5) @(negedge clk);
        check("a_done_single", done, 0);
        check_frame("a", bq, bh, bd);
        check("a_first_t0", q_idx[bq], exp_idx[0]);
        check("a_first_t1", q_idx[bq + TPIX], exp_idx[TPIX]);
        check("a_first_t4", q_idx[bq + 4 * TPIX], exp_idx[4 * TPIX]);
        check("a_last_index", q_idx[bq + NPIX - 1], NPIX - 1);

        // ---- Watchdog: histogram engine never answers
        hist_en = 1'b0;
        bd = n_done;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("w_hist_start", hist_start, 1);
        k = 0;
        for (int i = 0; i < WD + 20; i++) begin
            @(negedge clk);
            k++;
            if (k == 4) begin
                check("hist_bram_wen_iso", bram_wen, 0);
                check("hist_bram_addr", bram_addr, hist_addr);
                hist_ren = 1'b1; hist_wen = 1'b1; cdf_wen = 1'b0;
            end
            if (k == 3) begin
                hist_ren = 1'b0; hist_wen = 1'b0; hist_addr = AW'($urandom_range(0, 1000));
                cdf_wen = 1'b1; cdf_addr = AW'(60136);
            end
            if (err) break;
        end
        check("wdog_err", err, 1);
        check("wdog_cycles", 64'(k - 1), 64'(WD + 1));
        check("wdog_done", done, 1);
        check("wdog_bram_strobes", {bram_ren, bram_wen}, 0);
        @(negedge clk);
        hist_ren = 1'b0; hist_wen = 1'b0; hist_en = 1'b1;
        check("wdog_idle_busy", busy, 0);
        check("wdog_err_sticky", err, 1);
        check("wdog_done_count", 64'(n_done - bd), 64'd1);

        // ---- Frame B: new start clears err, then async reset in tile 7
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("b_err_cleared", err, 0);
        wait_cond(2, 7, 8000, ok);
        check("b_tile7_seen", ok, 1);
        cdf_wen = 1'b1; cdf_ren = 1'b1; cdf_addr = AW'($urandom_range(1, 100000)); cdf_din = 8'h3C;
        @(negedge clk);
        check("b_bram_pre_reset", bram_wen, 1);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_tile", tile_idx, 0);
        check("arst_index", map_index, 0);
        check("arst_starts", {hist_start, cdf_start, done, err}, 0);
        check("arst_bram", {bram_ren, bram_wen, bram_addr, bram_din}, 0);
        repeat (5) @(negedge clk);
        cdf_wen = 1'b0; cdf_ren = 1'b0;
        rst = 1'b0;

        // ---- Frame C: fresh run from tile 0
        bq = q_idx.size(); bh = n_hist; bd = n_done;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("c_hist_start", hist_start, 1);
        check("c_tile0", tile_idx, 0);
        wait_cond(3, 0, 8000, ok);
        check("c_done_seen", ok, 1);
        repeat (5) @(negedge clk);
        check_frame("c", bq, bh, bd);
        check("c_first_index", q_idx[bq], 0);
        check("c_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
